// File: rtl/sha_pkg.sv
// Shared SHA-256 constants, FSM state type and message-schedule/round helper functions.
// Used by the block controller, the schedule window and the transform datapath.
package sha_pkg;

   typedef enum logic [2:0] {
      IDLE,
      INIT,
      ROUND,
      ACC,
      OUT
   } state_e;

   // Element 0 sits in the MSBs so the packed form maps directly onto chain_h.
   localparam logic [0:7][31:0] H_INIT = {
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };

   localparam logic [0:63][31:0] K = {
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] s0(input logic [31:0] x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] s1(input logic [31:0] x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

   // Round-function helpers for the transform datapath.
   function automatic logic [31:0] big_s0(input logic [31:0] x);
      return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
   endfunction

   function automatic logic [31:0] big_s1(input logic [31:0] x);
      return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
   endfunction

   function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f, input logic [31:0] g);
      return (e & f) ^ (~e & g);
   endfunction

   function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
      return (a & b) ^ (a & c) ^ (b & c);
   endfunction

   // Eight independent 32-bit adds; carries never cross word boundaries.
   function automatic logic [255:0] add_words(input logic [255:0] a, input logic [255:0] b);
      logic [255:0] r;
      r = '0;
      for (int i = 0; i < 8; i++) r[32*i +: 32] = a[32*i +: 32] + b[32*i +: 32];
      return r;
   endfunction

endpackage

// File: rtl/sha_wsched.sv
// 16-word sliding message-schedule window: w_t is W[t]; each shift appends W[t+16].
module sha_wsched
   import sha_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         shift,
   input  logic [511:0] block_512,
   output logic [31:0]  w_t
);

   logic [31:0] win_q [16];
   logic [31:0] w_new;

   // win_q[j] holds W[t+j], so the recurrence taps are offsets 0, 1, 9 and 14.
   assign w_new = win_q[0] + s0(win_q[1]) + win_q[9] + s1(win_q[14]);
   assign w_t   = win_q[0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 16; i++) win_q[i] <= '0;
      end else if (load) begin
         for (int i = 0; i < 16; i++) win_q[i] <= block_512[511-32*i -: 32];
      end else if (shift) begin
         for (int i = 0; i < 15; i++) win_q[i] <= win_q[i+1];
         win_q[15] <= w_new;
      end
   end

endmodule

// File: rtl/sha_block_ctrl.sv
// SHA-256 block controller: accepts padded blocks, sequences the external round datapath,
// keeps the chaining value and presents the digest. SHA_PERF_CNT_EN adds the blk_cnt counter.
module sha_block_ctrl
   import sha_pkg::*;
#(
   parameter int NUM_ROUNDS = 64
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         blk_valid,
   output logic         blk_ready,
   input  logic [511:0] blk_data,
   input  logic         blk_first,
   input  logic         blk_last,
   output logic         rnd_init,
   output logic         rnd_en,
   output logic [31:0]  rnd_k,
   output logic [31:0]  rnd_w,
   output logic [255:0] chain_h,
   input  logic [255:0] state_in,
   output logic [255:0] digest,
   output logic         digest_valid,
   input  logic         digest_ready
`ifdef SHA_PERF_CNT_EN
   ,
   output logic [31:0]  blk_cnt
`endif
);

   localparam logic [5:0] LAST_IDX = 6'(NUM_ROUNDS - 1);

   state_e       state_q, state_d;
   logic [5:0]   idx_q, idx_d;
   logic         last_q;
   logic [255:0] chain_q;
   logic [255:0] digest_q;
   logic [255:0] chain_sum;
   logic [31:0]  w_t;
   logic         accept;

   assign accept    = blk_valid & blk_ready;
   assign chain_sum = add_words(chain_q, state_in);

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      blk_ready    = 1'b0;
      rnd_init     = 1'b0;
      rnd_en       = 1'b0;
      digest_valid = 1'b0;
      case (state_q)
         IDLE: begin
            blk_ready = 1'b1;
            if (blk_valid) state_d = INIT;
         end
         INIT: begin
            rnd_init = 1'b1;
            idx_d    = '0;
            state_d  = ROUND;
         end
         ROUND: begin
            rnd_en = 1'b1;
            // Index saturates at the last round and is cleared on exit.
            if (idx_q == LAST_IDX) begin
               idx_d   = '0;
               state_d = ACC;
            end else begin
               idx_d = idx_q + 6'd1;
            end
         end
         ACC: state_d = last_q ? OUT : IDLE;
         OUT: begin
            digest_valid = 1'b1;
            if (digest_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         last_q   <= 1'b0;
         chain_q  <= H_INIT;
         digest_q <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         if (accept) begin
            last_q <= blk_last;
            if (blk_first) chain_q <= H_INIT;
         end
         if (state_q == ACC) begin
            chain_q <= chain_sum;
            if (last_q) digest_q <= chain_sum;
         end
      end
   end

   sha_wsched u_wsched (
      .clk       (clk),
      .rst       (rst),
      .load      (accept),
      .shift     (rnd_en),
      .block_512 (blk_data),
      .w_t       (w_t)
   );

   assign rnd_k   = rnd_en ? K[idx_q] : '0;
   assign rnd_w   = rnd_en ? w_t : '0;
   assign chain_h = chain_q;
   assign digest  = digest_q;

`ifdef SHA_PERF_CNT_EN
   logic [31:0] blk_cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                  blk_cnt_q <= '0;
      else if (state_q == ACC)  blk_cnt_q <= blk_cnt_q + 32'd1;
   end

   assign blk_cnt = blk_cnt_q;
`endif

endmodule

// File: tb/tb_sha_block_ctrl.sv
// Self-checking bench for sha_block_ctrl with a behavioural SHA-256 round datapath and reference hash.
module tb_sha_block_ctrl;

   localparam int NR = 64;

   localparam logic [255:0] HI  = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
   localparam logic [255:0] ABC = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
   localparam logic [255:0] EMP = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
   localparam logic [255:0] TWO = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

   localparam logic [511:0] ABC_B  = {32'h61626380, 416'h0, 64'h18};
   localparam logic [511:0] EMP_B  = {32'h80000000, 480'h0};
   localparam logic [511:0] TWO_B1 = {256'h6162636462636465636465666465666765666768666768696768696a68696a6b,
                                      192'h696a6b6c6a6b6c6d6b6c6d6e6c6d6e6f6d6e6f706e6f7071,
                                      64'h8000000000000000};
   localparam logic [511:0] TWO_B2 = {448'h0, 64'h1c0};

   localparam logic [0:63][31:0] KT = {
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   logic         clk = 1'b0;
   logic         rst;
   logic         blk_valid, blk_ready, blk_first, blk_last;
   logic [511:0] blk_data;
   logic         rnd_init, rnd_en;
   logic [31:0]  rnd_k, rnd_w;
   logic [255:0] chain_h, state_in, digest;
   logic         digest_valid, digest_ready;
`ifdef SHA_PERF_CNT_EN
   logic [31:0]  blk_cnt;
`endif

   int checks = 0;
   int errors = 0;
   int ref_cnt = 0;

   always #5 clk = ~clk;

   sha_block_ctrl #(.NUM_ROUNDS(NR)) dut (
      .clk          (clk),
      .rst          (rst),
      .blk_valid    (blk_valid),
      .blk_ready    (blk_ready),
      .blk_data     (blk_data),
      .blk_first    (blk_first),
      .blk_last     (blk_last),
      .rnd_init     (rnd_init),
      .rnd_en       (rnd_en),
      .rnd_k        (rnd_k),
      .rnd_w        (rnd_w),
      .chain_h      (chain_h),
      .state_in     (state_in),
      .digest       (digest),
      .digest_valid (digest_valid),
      .digest_ready (digest_ready)
`ifdef SHA_PERF_CNT_EN
      ,
      .blk_cnt      (blk_cnt)
`endif
   );

   function automatic logic [31:0] rr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [255:0] sha_round(input logic [255:0] s, input logic [31:0] k, input logic [31:0] w);
      logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
      {a, b, c, d, e, f, g, h} = s;
      t1 = h + (rr(e, 6) ^ rr(e, 11) ^ rr(e, 25)) + ((e & f) ^ (~e & g)) + k + w;
      t2 = (rr(a, 2) ^ rr(a, 13) ^ rr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      return {t1 + t2, a, b, c, d + t1, e, f, g};
   endfunction

   function automatic logic [31:0] sched_w(input logic [511:0] blk, input int t);
      logic [31:0] w [64];
      for (int i = 0; i < 64; i++) begin
         if (i < 16) w[i] = blk[511-32*i -: 32];
         else w[i] = w[i-16] + (rr(w[i-15], 7) ^ rr(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-7]
                     + (rr(w[i-2], 17) ^ rr(w[i-2], 19) ^ (w[i-2] >> 10));
      end
      return w[t];
   endfunction

   function automatic logic [255:0] compress(input logic [255:0] h, input logic [511:0] blk);
      logic [255:0] s, r;
      s = h;
      for (int t = 0; t < 64; t++) s = sha_round(s, KT[t], sched_w(blk, t));
      for (int i = 0; i < 8; i++) r[32*i +: 32] = h[32*i +: 32] + s[32*i +: 32];
      return r;
   endfunction

   // Round datapath model driven by the controller's datapath ports.
   logic [255:0] dp_q = '0;
   always @(posedge clk) begin
      if (rnd_init)    dp_q <= chain_h;
      else if (rnd_en) dp_q <= sha_round(dp_q, rnd_k, rnd_w);
   end
   assign state_in = dp_q;

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   task automatic issue(input logic [511:0] d, input logic f, input logic l);
      int n;
      @(negedge clk);
      blk_data = d; blk_first = f; blk_last = l; blk_valid = 1'b1;
      n = 0;
      while (!blk_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!blk_ready) begin
         $display("FAIL accept_timeout actual=%0d expected=<200", n);
         $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
         $fatal(1, "accept timeout");
      end
      @(posedge clk);
      #1;
      blk_valid = 1'b0;
      blk_data = ~d; blk_first = ~f; blk_last = ~l;
   endtask

   task automatic run_blk(input logic [511:0] d, input logic f, input logic l,
                          input logic [255:0] exp, input int hold);
      int bad_ctl, bad_kw, bad_hold;
      logic ei, ee;
      digest_ready = (hold == 0);
      issue(d, f, l);
      ref_cnt++;
      bad_ctl = 0; bad_kw = 0;
      for (int i = 1; i <= NR + 2; i++) begin
         @(negedge clk);
         ei = (i == 1);
         ee = (i >= 2 && i <= NR + 1);
         if (rnd_init !== ei || rnd_en !== ee || blk_ready !== 1'b0 || digest_valid !== 1'b0) bad_ctl++;
         if (!ee && (rnd_k !== 32'h0 || rnd_w !== 32'h0)) bad_ctl++;
         if (ee && (rnd_k !== KT[i-2] || rnd_w !== sched_w(d, i - 2))) bad_kw++;
      end
      chk("ctrl_seq", 256'(bad_ctl), 256'd0);
      chk("rnd_kw", 256'(bad_kw), 256'd0);
      @(negedge clk);
      chk("dv_latency", 256'(digest_valid), 256'(l));
      if (l) begin
         chk("digest", digest, exp);
         bad_hold = 0;
         for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (digest_valid !== 1'b1 || digest !== exp || blk_ready !== 1'b0) bad_hold++;
         end
         if (hold > 0) chk("hold_stable", 256'(bad_hold), 256'd0);
         digest_ready = 1'b1;
         @(negedge clk);
         chk("out_release", 256'({digest_valid, blk_ready}), 256'(2'b01));
      end else begin
         chk("ready_after_blk", 256'(blk_ready), 256'd1);
      end
   endtask

   typedef struct {
      logic [511:0] d;
      logic         f;
      logic         l;
      logic         mdl;
      logic [255:0] exp;
   } vec_t;

   vec_t tab [10];

   initial begin
      logic [255:0] ref_chain, e;
      int bad;
      rst = 1'b1; blk_valid = 1'b0; blk_data = '0; blk_first = 1'b0; blk_last = 1'b0; digest_ready = 1'b1;

      tab[0] = '{ABC_B, 1'b1, 1'b1, 1'b0, ABC};
      tab[1] = '{EMP_B, 1'b1, 1'b1, 1'b0, EMP};
      tab[2] = '{TWO_B1, 1'b1, 1'b0, 1'b0, '0};
      tab[3] = '{TWO_B2, 1'b0, 1'b1, 1'b0, TWO};
      for (int i = 4; i < 10; i++) begin
         for (int j = 0; j < 16; j++) tab[i].d[32*j +: 32] = $urandom;
         tab[i].f   = ($urandom_range(0, 2) == 0);
         tab[i].l   = ($urandom_range(0, 1) == 1);
         tab[i].mdl = 1'b1;
         tab[i].exp = '0;
      end
      tab[4].f = 1'b0;
      tab[9].l = 1'b1;

      repeat (3) @(negedge clk);
      chk("rst_ctrl", 256'({blk_ready, rnd_init, rnd_en, digest_valid}), 256'(4'b1000));
      chk("rst_kw", 256'({rnd_k, rnd_w}), 256'd0);
      chk("rst_digest", digest, 256'd0);
      chk("rst_chain", chain_h, HI);
`ifdef SHA_PERF_CNT_EN
      chk("rst_blk_cnt", 256'(blk_cnt), 256'd0);
`endif
      rst = 1'b0;

      ref_chain = HI;
      for (int i = 0; i < 10; i++) begin
         if (tab[i].f) ref_chain = HI;
         ref_chain = compress(ref_chain, tab[i].d);
         e = tab[i].mdl ? ref_chain : tab[i].exp;
         run_blk(tab[i].d, tab[i].f, tab[i].l, e, 0);
      end

      run_blk(ABC_B, 1'b1, 1'b1, ABC, 20);

      // Reset while round 30 is executing.
      issue(ABC_B, 1'b1, 1'b1);
      repeat (32) @(negedge clk);
      chk("pre_rst_round", 256'(rnd_en), 256'd1);
      rst = 1'b1;
      #1;
      chk("rst_abort_ctrl", 256'({blk_ready, rnd_init, rnd_en, digest_valid}), 256'(4'b1000));
      chk("rst_abort_chain", chain_h, HI);
      @(negedge clk);
      rst = 1'b0;
      bad = 0;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         if (digest_valid !== 1'b0) bad++;
      end
      chk("no_spurious_dv", 256'(bad), 256'd0);
      run_blk(ABC_B, 1'b1, 1'b1, ABC, 0);

      // Reset while the digest is being held in OUT.
      digest_ready = 1'b0;
      issue(EMP_B, 1'b1, 1'b1);
      repeat (NR + 3) @(negedge clk);
      chk("pre_rst_out", 256'(digest_valid), 256'd1);
      rst = 1'b1;
      #1;
      chk("out_abort_dv", 256'({digest_valid, blk_ready}), 256'(2'b01));
      chk("out_abort_digest", digest, 256'd0);
      @(negedge clk);
      rst = 1'b0;
      digest_ready = 1'b1;
      ref_cnt = 0;

`ifdef SHA_PERF_CNT_EN
      for (int i = 0; i < 3; i++) begin
         logic [511:0] d;
         for (int j = 0; j < 16; j++) d[32*j +: 32] = $urandom;
         run_blk(d, 1'b1, 1'b1, compress(HI, d), 0);
      end
      chk("blk_cnt", 256'(blk_cnt), 256'(ref_cnt));
      rst = 1'b1;
      @(negedge clk);
      chk("blk_cnt_rst", 256'(blk_cnt), 256'd0);
      rst = 1'b0;
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
